sdram_pattern_checker: RTL and testbench
========================================

# sdram_pattern_checker

Parametrised SDRAM stress engine that fills a word range with a selectable pattern, reads it back, and counts mismatches. It runs repeated fill/verify passes, optionally inverting the pattern on alternate passes. It sits between the test top level (start/stop/status from the OSD) and one request port of the SDRAM controller. It is the generalised successor of the fixed address-pattern test, adding width parameters, pattern modes, pass counting and error capture.

## Interface
- ADDR_WIDTH, 22, word address width
- DATA_WIDTH, 16, SDRAM word width (even, 8..32)
- ERR_WIDTH, 16, error counter width
- PASS_WIDTH, 8, pass counter width

- clk  in  1  system clock
- reset_in  in  1  one clock; reset is synchronous and active-high
- start  in  1  pulse; begins a run when idle
- stop  in  1  pulse; ends the run after the current access
- mode  in  2  0 address, 1 LFSR, 2 walking-one, 3 checkerboard
- invert  in  1  invert pattern on odd passes
- addr_last  in  ADDR_WIDTH  last word address tested (range 0..addr_last)
- req  out  1  access request
- we  out  1  1 write, 0 read
- addr  out  ADDR_WIDTH  word address
- wdata  out  DATA_WIDTH  write data
- ack  in  1  write accepted / read data valid
- rdata  in  DATA_WIDTH  read data, valid with ack on reads
- busy  out  1  run in progress
- pass_count  out  PASS_WIDTH  completed passes, wraps
- err  out  1  one-cycle mismatch pulse
- err_count  out  ERR_WIDTH  mismatches, saturating
- first_err_valid  out  1  first_err_addr holds a capture
- first_err_addr  out  ADDR_WIDTH  address of first mismatch in run

## Operation
- States: IDLE, FILL, VERIFY, DRAIN.
- IDLE: start → latch mode, invert, addr_last; clear pass_count, err_count, first_err_valid; addr=0; seed LFSR; → FILL.
- start while busy is ignored. mode/invert/addr_last changes during a run are ignored.
- FILL: write pattern(addr) at addr for 0..addr_last; after ack at addr_last → addr=0, reseed LFSR, → VERIFY.
- VERIFY: read each addr; on ack compare rdata with pattern(addr). After ack at addr_last → pass_count+1 (wraps), reseed, addr=0, → FILL.
- stop in FILL/VERIFY: if req is outstanding → DRAIN (wait for ack, compare if read) → IDLE; otherwise → IDLE directly. Counters and captures are held in IDLE.
- Pattern p(addr), before inversion:
  - mode 0: addr zero-extended or truncated to DATA_WIDTH.
  - mode 1: low DATA_WIDTH bits of a 32-bit Galois LFSR (poly 0x80200003, seed 0xACE12468). The LFSR reseeds at each phase start and advances once per ack, so fill and verify sequences are identical.
  - mode 2: 1 << (addr mod DATA_WIDTH).
  - mode 3: addr[0]==0 ? {DATA_WIDTH/2{2'b10}} : {DATA_WIDTH/2{2'b01}}.
- Inversion: if latched invert=1 and pass_count[0]=1, the pattern is XORed with all-ones. Fill and verify within a pass use the same polarity.
- Mismatch handling:
  - err pulses.
  - err_count increments and saturates at all-ones.
  - If first_err_valid=0, capture addr into first_err_addr and set first_err_valid.
- addr_last=0: each pass is one write and one read.

## Timing
- Reset values: req=0, we=0, addr=0, wdata=0, busy=0, pass_count=0, err=0, err_count=0, first_err_valid=0, first_err_addr=0; state IDLE. A reset mid-access drops req on the next edge; no completion is awaited.
- start sampled at edge T → busy=1, req=1, we=1, addr=0, wdata=p(0) at T+1.
- Handshake: req/we/addr/wdata stay stable while ack=0. On the edge where ack=1, the next access is presented in the following cycle, so req may stay high back-to-back. Maximum throughput is one access per cycle.
- On a read, ack on edge T → err and updated err_count/first_err_* visible at T+1.
- Phase/pass transitions add no idle cycle. The pass_count increment is visible the cycle after the final verify ack.
- stop and ack on the same edge: that access completes, then → IDLE with busy=0 at the next cycle.
- Compare uses the rdata registered with ack. ack while req=0 is ignored.

## Test plan
- Mode 0, addr_last=3, zero-wait model: writes 0,1,2,3 at 0..3. Then four reads, then pass_count=1 after the 8th ack; err_count stays 0.
- Fault model flips rdata bit0 at address 2, mode 0: err pulses once per pass; after 3 passes err_count=3, first_err_addr=2, first_err_valid=1.
- ERR_WIDTH=4, model returns 0 always, mode 3, addr_last=31: err_count reaches 15 and holds; first_err_addr=0.
- invert=1, mode 2, DATA_WIDTH=16: pass 0 writes 0x0001 at addr 0 and 0x0002 at addr 1; pass 1 writes 0xFFFE at addr 0 and 0xFFFD at addr 1; no errors reported.
- Model holds ack low 5 cycles per access: req/addr/wdata are constant across the stall; mode 1 fill and verify data sequences match and no errors occur.
- stop during VERIFY with a read outstanding: the bench sees one further ack, then busy=0 and req=0. With a further run, reset_in mid-FILL gives all outputs their reset values one cycle later.

Source files
------------

// File: rtl/sdram_pattern_checker_if.sv
// sdram_pattern_checker_if: request/acknowledge port between the pattern checker and one SDRAM controller port
interface sdram_pattern_checker_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sdram_pattern_checker.sv
// sdram_pattern_checker: repeated fill/verify passes over words 0..addr_last with selectable patterns,
// pass counting, saturating mismatch count and first-error capture.
module sdram_pattern_checker #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16,
    parameter int ERR_WIDTH  = 16,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic                  invert,
    input  logic [ADDR_WIDTH-1:0] addr_last,
    sdram_pattern_checker_if.master mem,
    output logic                  busy,
    output logic [PASS_WIDTH-1:0] pass_count,
    output logic                  err,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [31:0] POLY = 32'h80200003;
    typedef enum logic [1:0] {IDLE, FILL, VERIFY, DRAIN} state_t;
    state_t                state;
    logic [1:0]            m_mode;
    logic                  m_inv;
    logic [ADDR_WIDTH-1:0] m_last;
    logic [31:0]           lfsr;
    logic                  last;
    logic                  hit;
    logic                  nxt_pol;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [31:0]           nxt_lfsr;
    logic [DATA_WIDTH-1:0] cur_pat;
    logic [DATA_WIDTH-1:0] nxt_pat;
    logic [DATA_WIDTH-1:0] start_pat;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] md, input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [31:0] l, input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = md == 2'd0 ? DATA_WIDTH'(a) :
            md == 2'd1 ? l[DATA_WIDTH-1:0] :
            md == 2'd2 ? DATA_WIDTH'(1) << (a % DATA_WIDTH) :
            a[0] ? {DATA_WIDTH/2{2'b01}} : {DATA_WIDTH/2{2'b10}};
        return inv ? ~p : p;
    endfunction

    // The next access is prepared from the current one so a completing ack can be followed back-to-back.
    always_comb begin
        last      = mem.addr == m_last;
        nxt_addr  = last ? '0 : mem.addr + 1'b1;
        nxt_lfsr  = last ? SEED : (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'd0);
        nxt_pol   = m_inv & (pass_count[0] ^ (state == VERIFY && last));
        cur_pat   = pattern(m_mode, mem.addr, lfsr, m_inv & pass_count[0]);
        nxt_pat   = pattern(m_mode, nxt_addr, nxt_lfsr, nxt_pol);
        start_pat = pattern(mode, '0, SEED, 1'b0);
        hit       = state != IDLE && mem.req && mem.ack && !mem.we && mem.rdata != cur_pat;
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state           <= IDLE;
            mem.req         <= 1'b0;
            mem.we          <= 1'b0;
            mem.addr        <= '0;
            mem.wdata       <= '0;
            busy            <= 1'b0;
            pass_count      <= '0;
            err             <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            m_mode          <= 2'd0;
            m_inv           <= 1'b0;
            m_last          <= '0;
            lfsr            <= SEED;
        end else begin
            err <= hit;
            if (hit) begin
                err_count <= &err_count ? err_count : err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= mem.addr;
                end
            end
            case (state)
                IDLE: if (start) begin
                    m_mode          <= mode;
                    m_inv           <= invert;
                    m_last          <= addr_last;
                    pass_count      <= '0;
                    err_count       <= '0;
                    first_err_valid <= 1'b0;
                    lfsr            <= SEED;
                    mem.addr        <= '0;
                    mem.req         <= 1'b1;
                    mem.we          <= 1'b1;
                    mem.wdata       <= start_pat;
                    busy            <= 1'b1;
                    state           <= FILL;
                end
                FILL, VERIFY: if (mem.ack) begin
                    mem.addr  <= nxt_addr;
                    lfsr      <= nxt_lfsr;
                    mem.wdata <= nxt_pat;
                    if (last) begin
                        state  <= state == FILL ? VERIFY : FILL;
                        mem.we <= state == VERIFY;
                        if (state == VERIFY) pass_count <= pass_count + 1'b1;
                    end
                    if (stop) begin
                        state   <= IDLE;
                        mem.req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end else if (stop) state <= DRAIN;
                default: if (mem.ack) begin
                    state   <= IDLE;
                    mem.req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_pattern_checker.sv
// tb_sdram_pattern_checker: memory responder with stall/fault injection and a stream-level reference model.
module tb_sdram_pattern_checker;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int EW = 4;
    localparam int PW = 8;
    localparam int ESAT = (1 << EW) - 1;
    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [31:0] POLY = 32'h80200003;

    typedef struct {
        logic [1:0] mode;
        logic       inv;
        int         last;
        int         fault;
        int         wt;
        int         passes;
        int         exp_err;
        logic       exp_fev;
        int         exp_fea;
        logic       fixed;
    } case_t;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          invert = 1'b0;
    logic [AW-1:0] addr_last = '0;
    logic          busy, err, fev;
    logic [PW-1:0] pass_count;
    logic [EW-1:0] err_count;
    logic [AW-1:0] fea;
    int            checks = 0;
    int            errors = 0;
    int            fault = 0;
    int            wt = 0;
    int            stall = 0;
    logic [DW-1:0] mem_arr [64];
    logic [31:0]   lseq [64];

    logic [1:0]    m_mode;
    logic          m_inv;
    int            m_last, n, e_err, e_fea, e_pass, acks;
    logic          e_fev, e_errp, stalled, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    int            per, w, ea;
    logic          ewe;
    logic [DW-1:0] ed;
    case_t         tbl [$];

    sdram_pattern_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_pattern_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW), .PASS_WIDTH(PW)) dut (
        .clk(clk), .reset_in(reset_in), .start(start), .stop(stop), .mode(mode), .invert(invert),
        .addr_last(addr_last), .mem(bus.master), .busy(busy), .pass_count(pass_count), .err(err),
        .err_count(err_count), .first_err_valid(fev), .first_err_addr(fea)
    );

    always #5 clk = ~clk;

    assign bus.ack   = bus.req && stall >= wt;
    assign bus.rdata = fault == 2 ? '0 : mem_arr[bus.addr[5:0]] ^ DW'(fault == 1 && bus.addr == AW'(2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat_ref(input logic [1:0] md, input int a, input logic inv);
        logic [DW-1:0] p;
        case (md)
            2'd0: p = DW'(a);
            2'd1: p = lseq[a][DW-1:0];
            2'd2: p = DW'(1) << (a % DW);
            default: p = a[0] ? 16'h5555 : 16'hAAAA;
        endcase
        return inv ? ~p : p;
    endfunction

    // Expected access stream: each pass is writes 0..last then reads 0..last; LFSR index equals the address.
    always @(posedge clk) begin
        e_errp = 1'b0;
        if (reset_in) begin
            n = 0; e_err = 0; e_fev = 1'b0; e_fea = 0; e_pass = 0; stalled = 1'b0;
            stall <= 0;
        end else begin
            if (start && !busy) begin
                n = 0; e_err = 0; e_fev = 1'b0; e_pass = 0;
                m_mode = mode; m_inv = invert; m_last = int'(addr_last);
            end
            stalled = bus.req && !bus.ack;
            s_we = bus.we; s_addr = bus.addr; s_wdata = bus.wdata;
            stall <= stalled ? stall + 1 : 0;
            if (bus.req && bus.ack) begin
                per = 2 * (m_last + 1);
                w   = n % per;
                ewe = w <= m_last;
                ea  = ewe ? w : w - m_last - 1;
                ed  = pat_ref(m_mode, ea, m_inv && ((n / per) % 2 == 1));
                chk("access_we", 64'(bus.we), 64'(ewe));
                chk("access_addr", 64'(bus.addr), 64'(ea));
                if (ewe) begin
                    chk("write_data", 64'(bus.wdata), 64'(ed));
                    mem_arr[bus.addr[5:0]] <= bus.wdata;
                end else if (bus.rdata != ed) begin
                    e_errp = 1'b1;
                    if (e_err < ESAT) e_err++;
                    if (!e_fev) begin e_fev = 1'b1; e_fea = ea; end
                end
                n++;
                e_pass = (n / per) % 256;
                acks++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_in) begin
            chk("err_pulse", 64'(err), 64'(e_errp));
            chk("err_count", 64'(err_count), 64'(e_err));
            chk("first_err_valid", 64'(fev), 64'(e_fev));
            if (e_fev) chk("first_err_addr", 64'(fea), 64'(e_fea));
            chk("pass_count", 64'(pass_count), 64'(e_pass));
            if (stalled) begin
                chk("stall_req", 64'(bus.req), 64'(1));
                chk("stall_we", 64'(bus.we), 64'(s_we));
                chk("stall_addr", 64'(bus.addr), 64'(s_addr));
                chk("stall_wdata", 64'(bus.wdata), 64'(s_wdata));
            end
        end
    end

    task automatic start_run(input case_t c);
        @(negedge clk);
        mode = c.mode; invert = c.inv; addr_last = AW'(c.last); fault = c.fault; wt = c.wt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_req", 64'(bus.req), 64'(1));
        chk("start_we", 64'(bus.we), 64'(1));
        chk("start_addr", 64'(bus.addr), 64'(0));
        mode = 2'($urandom); invert = 1'($urandom); addr_last = AW'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 20000) begin @(negedge clk); k++; end
        chk(nm, 64'(k < 20000), 64'(1));
    endtask

    task automatic run_case(input case_t c);
        int k = 0;
        start_run(c);
        while (pass_count != PW'(c.passes) && k < 20000) begin @(negedge clk); k++; end
        chk("pass_timeout", 64'(k < 20000), 64'(1));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("stop_timeout");
        repeat (2) @(negedge clk);
        chk("pass_held", 64'(pass_count), 64'(c.passes));
        if (c.fixed) begin
            chk("case_err_count", 64'(err_count), 64'(c.exp_err));
            chk("case_first_valid", 64'(fev), 64'(c.exp_fev));
            if (c.exp_fev) chk("case_first_addr", 64'(fea), 64'(c.exp_fea));
        end
    endtask

    initial begin
        case_t c;
        int    a0, k;
        logic [31:0] l;
        l = SEED;
        for (int i = 0; i < 64; i++) begin
            lseq[i] = l;
            l = l[0] ? (l >> 1) ^ POLY : l >> 1;
            mem_arr[i] = '0;
        end
        acks = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", 64'(bus.req), 64'(0));
        chk("rst_we", 64'(bus.we), 64'(0));
        chk("rst_addr", 64'(bus.addr), 64'(0));
        chk("rst_wdata", 64'(bus.wdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pass", 64'(pass_count), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_errcnt", 64'(err_count), 64'(0));
        chk("rst_fev", 64'(fev), 64'(0));
        chk("rst_fea", 64'(fea), 64'(0));
        reset_in = 1'b0;
        //         mode  inv   last fault wt passes err fev  fea fixed
        tbl.push_back('{2'd0, 1'b0, 3,  0,    0, 1,     0,  1'b0, 0, 1'b1});
        tbl.push_back('{2'd0, 1'b0, 3,  1,    0, 3,     3,  1'b1, 2, 1'b1});
        tbl.push_back('{2'd3, 1'b0, 31, 2,    0, 1,     15, 1'b1, 0, 1'b1});
        tbl.push_back('{2'd2, 1'b1, 1,  0,    0, 2,     0,  1'b0, 0, 1'b1});
        tbl.push_back('{2'd1, 1'b0, 7,  0,    5, 1,     0,  1'b0, 0, 1'b1});
        tbl.push_back('{2'd1, 1'b1, 0,  0,    1, 2,     0,  1'b0, 0, 1'b1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{2'($urandom), 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 2),
                            $urandom_range(0, 3), $urandom_range(1, 3), 0, 1'b0, 0, 1'b0});
        foreach (tbl[i]) run_case(tbl[i]);

        // Stop with a read stalled: exactly one more ack, then idle.
        c = '{2'd0, 1'b0, 3, 0, 3, 1, 0, 1'b0, 0, 1'b0};
        start_run(c);
        k = 0;
        while (!(bus.req && !bus.we && !bus.ack) && k < 1000) begin @(negedge clk); k++; end
        chk("verify_stall_timeout", 64'(k < 1000), 64'(1));
        a0 = acks;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("drain_timeout");
        chk("drain_acks", 64'(acks - a0), 64'(1));
        chk("drain_busy", 64'(busy), 64'(0));
        chk("drain_req", 64'(bus.req), 64'(0));

        // Reset in the middle of a fill.
        c = '{2'd1, 1'b1, 15, 0, 0, 1, 0, 1'b0, 0, 1'b0};
        start_run(c);
        repeat (4) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 64'(bus.req), 64'(0));
        chk("mid_rst_we", 64'(bus.we), 64'(0));
        chk("mid_rst_addr", 64'(bus.addr), 64'(0));
        chk("mid_rst_wdata", 64'(bus.wdata), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_pass", 64'(pass_count), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk("mid_rst_errcnt", 64'(err_count), 64'(0));
        chk("mid_rst_fev", 64'(fev), 64'(0));
        chk("mid_rst_fea", 64'(fea), 64'(0));
        reset_in = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
